// File: rtl/handshake_pkg.sv
// handshake_pkg: shared encodings and helpers for handshake arbiters
package handshake_pkg;
    localparam logic SLOT_EMPTY = 1'b0;
    localparam logic SLOT_FULL = 1'b1;
    typedef enum logic {ST_EMPTY = SLOT_EMPTY, ST_FULL = SLOT_FULL} slot_t;
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/handshake_rr_share_if.sv
// handshake_rr_share_if: producer-side channels and shared consumer handshake
interface handshake_rr_share_if
    import handshake_pkg::*;
#(
    parameter int SIZE = 2,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_WIDTH = clog2_min1(SIZE)
);
    logic [SIZE*DATA_WIDTH-1:0] ins;
    logic [SIZE-1:0] ins_valid;
    logic [SIZE-1:0] ins_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic [INDEX_WIDTH-1:0] outs_index;
    logic outs_valid;
    logic outs_ready;
    modport master (
        output ins, ins_valid, outs_ready,
        input ins_ready, outs, outs_index, outs_valid
    );
    modport slave (
        input ins, ins_valid, outs_ready,
        output ins_ready, outs, outs_index, outs_valid
    );
endinterface

// File: rtl/handshake_rr_share_rr_pick.sv
// rr_pick: round-robin pick of the first request at or after ptr
module rr_pick
    import handshake_pkg::*;
#(
    parameter int SIZE = 2,
    parameter int INDEX_WIDTH = clog2_min1(SIZE)
) (
    input logic [SIZE-1:0] req,
    input logic [INDEX_WIDTH-1:0] ptr,
    output logic any,
    output logic [INDEX_WIDTH-1:0] grant_idx,
    output logic [SIZE-1:0] grant_onehot
);
    logic [SIZE-1:0] rot;
    int off;
    int sum;
    always_comb begin
        rot = SIZE'({req, req} >> ptr);
        off = 0;
        for (int i = SIZE - 1; i >= 0; i--) off = rot[i] ? i : off;
        sum = int'(ptr) + off;
        grant_idx = INDEX_WIDTH'(sum >= SIZE ? sum - SIZE : sum);
        any = |req;
        grant_onehot = any ? SIZE'(1) << grant_idx : '0;
    end
endmodule

// File: rtl/handshake_rr_share.sv
// handshake_rr_share: round-robin share of one registered output slot among SIZE producers
module handshake_rr_share
    import handshake_pkg::*;
#(
    parameter int SIZE = 2,
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_WIDTH = clog2_min1(SIZE)
) (
    input logic clk,
    input logic rst,
    handshake_rr_share_if.slave bus
);
    slot_t state, state_n;
    logic [INDEX_WIDTH-1:0] ptr, g, idx_q;
    logic [SIZE-1:0] onehot;
    logic [DATA_WIDTH-1:0] outs_q;
    logic any, xfer;
    rr_pick #(.SIZE(SIZE), .INDEX_WIDTH(INDEX_WIDTH)) u_pick (
        .req(bus.ins_valid),
        .ptr(ptr),
        .any(any),
        .grant_idx(g),
        .grant_onehot(onehot)
    );
    always_comb begin
        xfer = any & (state == ST_EMPTY | bus.outs_ready) & ~rst;
        state_n = xfer ? ST_FULL : bus.outs_ready ? ST_EMPTY : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            outs_q <= '0;
            idx_q <= '0;
            ptr <= '0;
        end else begin
            state <= state_n;
            if (xfer) begin
                outs_q <= bus.ins[int'(g)*DATA_WIDTH +: DATA_WIDTH];
                idx_q <= g;
                ptr <= (g == INDEX_WIDTH'(SIZE - 1)) ? '0 : g + 1'b1;
            end
        end
    end
    assign bus.ins_ready = xfer ? onehot : '0;
    assign bus.outs = outs_q;
    assign bus.outs_index = idx_q;
    assign bus.outs_valid = (state == ST_FULL);
endmodule
